// File: rtl/sparc_mem_pkg.sv
// Shared encodings for the SPARC main-memory block.
// Size/RW codes and the MFA/MFC handshake state type.
package sparc_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic RD = 1'b1;
  localparam logic WR = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  function automatic logic [31:0] ext_half(
    input logic       sgn,
    input logic [15:0] h
  );
    return {{16{sgn & h[15]}}, h};
  endfunction

  function automatic logic [31:0] ext_byte(
    input logic       sgn,
    input logic [7:0] b
  );
    return {{24{sgn & b[7]}}, b};
  endfunction

endpackage

// File: rtl/mem_align_fmt.sv
// Alignment check, big-endian lane mapping and load extension.
// Lane i always refers to byte address a+i.
module mem_align_fmt
  import sparc_mem_pkg::*;
(
  input  logic [1:0]      size,
  input  logic            sgn,
  input  logic [1:0]      addr_lo,
  input  logic [31:0]     wdata,
  input  logic [3:0][7:0] rd_lane,
  output logic            mis,
  output logic [31:0]     rdata,
  output logic [3:0][7:0] wr_lane,
  output logic [3:0]      wr_mask
);

  logic is_byte;
  logic is_half;
  logic is_word;

  assign is_byte = (size == SZ_BYTE);
  assign is_half = (size == SZ_HALF);
  assign is_word = size[1];

  always_comb begin
    mis     = 1'b0;
    rdata   = '0;
    wr_lane = '0;
    wr_mask = '0;
    unique case (1'b1)
      is_byte: begin
        rdata      = ext_byte(sgn, rd_lane[0]);
        wr_lane[0] = wdata[7:0];
        wr_mask    = 4'b0001;
      end
      is_half: begin
        mis        = addr_lo[0];
        rdata      = ext_half(sgn, {rd_lane[0], rd_lane[1]});
        wr_lane[0] = wdata[15:8];
        wr_lane[1] = wdata[7:0];
        wr_mask    = 4'b0011;
      end
      is_word: begin
        mis        = |addr_lo;
        rdata      = {rd_lane[0], rd_lane[1],
                      rd_lane[2], rd_lane[3]};
        wr_lane[0] = wdata[31:24];
        wr_lane[1] = wdata[23:16];
        wr_lane[2] = wdata[15:8];
        wr_lane[3] = wdata[7:0];
        wr_mask    = 4'b1111;
      end
      default: ;
    endcase
    // a misaligned access must neither write nor return data
    if (mis) begin
      rdata   = '0;
      wr_mask = '0;
    end
  end

endmodule

// File: rtl/mfc_byte_ram.sv
// Byte-addressed big-endian main memory with MFA/MFC handshake.
// Array has no reset so contents survive Reset.
module mfc_byte_ram
  import sparc_mem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MFA,
  input  logic        RW,
  input  logic [1:0]  SIZE,
  input  logic        SIGNED,
  input  logic [31:0] ADDR,
  input  logic [31:0] DATA_IN,
  output logic [31:0] DATA_OUT,
  output logic        MFC,
  output logic        ALIGN_ERR
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0] ram [DEPTH];

  mem_state_t      state;
  logic [3:0]      cnt;
  logic            rw_q;
  logic [1:0]      size_q;
  logic            sgn_q;
  logic [AW-1:0]   addr_q;
  logic [31:0]     din_q;

  logic [AW-1:0]   lane_addr [4];
  logic [3:0][7:0] rd_lane;
  logic [3:0][7:0] wr_lane;
  logic [3:0]      wr_mask;
  logic            mis;
  logic [31:0]     rd_data;
  logic            fire;
  logic            we;
  logic            unused_addr;

  assign unused_addr = ^ADDR[31:AW];

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign lane_addr[i] = addr_q + AW'(i);
    assign rd_lane[i]   = ram[lane_addr[i]];
  end

  mem_align_fmt u_fmt (
    .size    (size_q),
    .sgn     (sgn_q),
    .addr_lo (addr_q[1:0]),
    .wdata   (din_q),
    .rd_lane (rd_lane),
    .mis     (mis),
    .rdata   (rd_data),
    .wr_lane (wr_lane),
    .wr_mask (wr_mask)
  );

  assign fire = (state == BUSY) && MFA && (cnt == 4'd0);
  assign we   = fire && (rw_q == WR) && !Reset;

  always_ff @(posedge Clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_mask[i]) ram[lane_addr[i]] <= wr_lane[i];
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      cnt       <= '0;
      rw_q      <= RD;
      size_q    <= SZ_BYTE;
      sgn_q     <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      DATA_OUT  <= '0;
      MFC       <= 1'b0;
      ALIGN_ERR <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (MFA) begin
            rw_q   <= RW;
            size_q <= SIZE;
            sgn_q  <= SIGNED;
            addr_q <= ADDR[AW-1:0];
            din_q  <= DATA_IN;
            cnt    <= 4'(LATENCY - 1);
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (!MFA) begin
            state <= IDLE;
          end else if (cnt == 4'd0) begin
            MFC       <= 1'b1;
            ALIGN_ERR <= mis;
            // rd_data is zero when misaligned
            if (rw_q == RD || mis) DATA_OUT <= rd_data;
            state <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          if (!MFA) begin
            MFC       <= 1'b0;
            ALIGN_ERR <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mfc_byte_ram.sv
// Directed bench for mfc_byte_ram: latency, lanes, alignment,
// wrap, abort and mid-access reset.
module tb_mfc_byte_ram;
  import sparc_mem_pkg::*;

  localparam int LAT = 2;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        MFA = 1'b0;
  logic        RW = RD;
  logic [1:0]  SIZE = SZ_WORD;
  logic        SIGNED = 1'b0;
  logic [31:0] ADDR = '0;
  logic [31:0] DATA_IN = '0;
  logic [31:0] DATA_OUT;
  logic        MFC;
  logic        ALIGN_ERR;

  int checks = 0;
  int errors = 0;

  mfc_byte_ram #(.DEPTH(256), .LATENCY(LAT)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .MFA       (MFA),
    .RW        (RW),
    .SIZE      (SIZE),
    .SIGNED    (SIGNED),
    .ADDR      (ADDR),
    .DATA_IN   (DATA_IN),
    .DATA_OUT  (DATA_OUT),
    .MFC       (MFC),
    .ALIGN_ERR (ALIGN_ERR)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic access(input string tag,
                        input logic rw,
                        input logic [1:0] sz,
                        input logic sg,
                        input logic [31:0] a,
                        input logic [31:0] d,
                        input logic exp_al,
                        input logic chk_d,
                        input logic [31:0] exp_d);
    int n;
    logic [31:0] held;
    n = 0;
    @(negedge Clk);
    MFA = 1'b1; RW = rw; SIZE = sz; SIGNED = sg;
    ADDR = a; DATA_IN = d;
    @(posedge Clk);
    #1;
    // scramble inputs to prove they were latched
    RW = ~rw; SIZE = ~sz; SIGNED = ~sg;
    ADDR = ~a; DATA_IN = ~d;
    while (n < 20) begin
      @(posedge Clk);
      #1;
      n++;
      if (MFC === 1'b1) break;
    end
    chk({tag, ".lat"}, 32'(n), 32'(LAT));
    chk({tag, ".al"}, {31'd0, ALIGN_ERR}, {31'd0, exp_al});
    if (chk_d) chk({tag, ".data"}, DATA_OUT, exp_d);
    held = DATA_OUT;
    @(posedge Clk);
    #1;
    chk({tag, ".hold"}, {31'd0, MFC}, 32'd1);
    chk({tag, ".hold_d"}, DATA_OUT, held);
    @(negedge Clk);
    MFA = 1'b0;
    @(posedge Clk);
    #1;
    chk({tag, ".mfc_clr"}, {31'd0, MFC}, 32'd0);
    chk({tag, ".al_clr"}, {31'd0, ALIGN_ERR}, 32'd0);
    chk({tag, ".keep_d"}, DATA_OUT, held);
  endtask

  initial begin
    #2 Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst.mfc", {31'd0, MFC}, 32'd0);
    chk("rst.al", {31'd0, ALIGN_ERR}, 32'd0);
    chk("rst.data", DATA_OUT, 32'd0);
    @(negedge Clk);
    Reset = 1'b0;

    access("w0", WR, SZ_WORD, 1'b0, 32'd0, 32'h9C04_4012,
           1'b0, 1'b0, '0);
    access("r0w", RD, SZ_WORD, 1'b0, 32'd0, '0,
           1'b0, 1'b1, 32'h9C04_4012);
    access("r0bs", RD, SZ_BYTE, 1'b1, 32'd0, '0,
           1'b0, 1'b1, 32'hFFFF_FF9C);
    access("r2hu", RD, SZ_HALF, 1'b0, 32'd2, '0,
           1'b0, 1'b1, 32'h0000_4012);
    access("r0hs", RD, SZ_HALF, 1'b1, 32'd0, '0,
           1'b0, 1'b1, 32'hFFFF_9C04);
    access("r1bu", RD, SZ_BYTE, 1'b0, 32'd1, '0,
           1'b0, 1'b1, 32'h0000_0004);
    access("r3w11", RD, 2'b11, 1'b1, 32'd0, '0,
           1'b0, 1'b1, 32'h9C04_4012);

    access("w4", WR, SZ_WORD, 1'b0, 32'd4, 32'h1122_3344,
           1'b0, 1'b0, '0);
    access("w6h", WR, SZ_HALF, 1'b0, 32'd6, 32'h1234_ABCD,
           1'b0, 1'b0, '0);
    access("r4w", RD, SZ_WORD, 1'b0, 32'd4, '0,
           1'b0, 1'b1, 32'h1122_ABCD);

    access("w2mis", WR, SZ_WORD, 1'b0, 32'd2, 32'hDEAD_BEEF,
           1'b1, 1'b1, 32'd0);
    access("r0un", RD, SZ_WORD, 1'b0, 32'd0, '0,
           1'b0, 1'b1, 32'h9C04_4012);
    access("r4un", RD, SZ_WORD, 1'b0, 32'd4, '0,
           1'b0, 1'b1, 32'h1122_ABCD);
    access("r1hmis", RD, SZ_HALF, 1'b0, 32'd1, '0,
           1'b1, 1'b1, 32'd0);

    access("w104", WR, SZ_WORD, 1'b0, 32'h0000_0104,
           32'h5566_7788, 1'b0, 1'b0, '0);
    access("r4wrap", RD, SZ_WORD, 1'b0, 32'd4, '0,
           1'b0, 1'b1, 32'h5566_7788);

    // abort: one BUSY cycle then drop MFA
    @(negedge Clk);
    MFA = 1'b1; RW = WR; SIZE = SZ_WORD;
    ADDR = 32'd4; DATA_IN = 32'hCAFE_F00D;
    @(posedge Clk);
    @(posedge Clk);
    #1;
    chk("abort.busy", {31'd0, MFC}, 32'd0);
    @(negedge Clk);
    MFA = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
    chk("abort.mfc", {31'd0, MFC}, 32'd0);
    access("r4abort", RD, SZ_WORD, 1'b0, 32'd4, '0,
           1'b0, 1'b1, 32'h5566_7788);

    // reset in BUSY of a write to word 0
    @(negedge Clk);
    MFA = 1'b1; RW = WR; SIZE = SZ_WORD;
    ADDR = 32'd0; DATA_IN = 32'h0000_0000;
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    chk("midrst.mfc", {31'd0, MFC}, 32'd0);
    chk("midrst.data", DATA_OUT, 32'd0);
    chk("midrst.al", {31'd0, ALIGN_ERR}, 32'd0);
    @(negedge Clk);
    MFA = 1'b0;
    Reset = 1'b0;
    access("r0post", RD, SZ_WORD, 1'b0, 32'd0, '0,
           1'b0, 1'b1, 32'h9C04_4012);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mfc_byte_ram.md
# mfc_byte_ram

Byte-addressed, big-endian main memory for the SPARC datapath, directly downstream of the control unit and the MAR/MDR registers. Serves loads and stores of byte, halfword and word size through the MFA/MFC (memory function active / complete) handshake, with a programmable wait-state latency. Flags misaligned accesses so the control unit can raise a trap. Memory contents survive reset, so benches can preload the array before releasing reset.

## Interface
- DEPTH, 256: memory size in bytes, power of two; address index is ADDR[log2(DEPTH)-1:0].
- LATENCY, 2: cycles from request acceptance to MFC; legal range 1..15.
- Clk  in  1  clock; all state changes on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- MFA  in  1  memory function active; request held high by the control unit until MFC is seen.
- RW  in  1  1 = read (load), 0 = write (store).
- SIZE  in  2  00 byte, 01 halfword, 10 word, 11 treated as word.
- SIGNED  in  1  loads only: 1 sign-extends, 0 zero-extends byte and halfword data.
- ADDR  in  32  byte address (from MAR).
- DATA_IN  in  32  store data (from MDR); byte uses [7:0], halfword uses [15:0].
- DATA_OUT  out  32  load data (to MDR mux); reset 0.
- MFC  out  1  memory function complete; reset 0.
- ALIGN_ERR  out  1  misaligned access flag, valid while MFC=1; reset 0.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: MFA=1 at an edge latches RW, SIZE, SIGNED, ADDR and DATA_IN into internal registers, loads the wait counter with LATENCY-1, and moves to BUSY. Inputs may change after acceptance.
- BUSY: the counter decrements each edge. At the edge where the counter is 0, the latched access is performed, MFC is set to 1, and the FSM moves to DONE.
- Abort: MFA=0 at any BUSY edge returns the FSM to IDLE. No write occurs and MFC never rises.
- DONE: MFC, DATA_OUT and ALIGN_ERR are held. MFA=0 at an edge clears MFC and ALIGN_ERR and returns the FSM to IDLE. DATA_OUT keeps its last value.
- Big-endian layout: ram[a] holds the most significant byte of the word.
  - Word: {ram[a], ram[a+1], ram[a+2], ram[a+3]}.
  - Halfword: {ram[a], ram[a+1]}.
- Alignment: halfword requires a[0]=0; word requires a[1:0]=00. A misaligned access sets ALIGN_ERR=1 with MFC, performs no write, and drives DATA_OUT to 0.
- Address bits at or above log2(DEPTH) are ignored, so addresses wrap modulo DEPTH.
- Load extension: byte loads fill [31:8] and halfword loads fill [31:16] with zeros or with the sign bit, per SIGNED.
- Reset, including mid-access: FSM goes to IDLE and all outputs clear to 0. A pending write is dropped. The array is not cleared.

## Timing
- Request accepted at edge k. MFC rises at edge k+LATENCY. The write commits at that same edge, and read data is valid from that edge.
- MFA sampled low at DONE edge n: MFC falls at edge n. The earliest next acceptance is edge n+1.
- A MFA that stays high in DONE holds MFC high indefinitely; no second access starts.
- Maximum throughput is one access per LATENCY+2 cycles.
- Reads have no side effects. Read data reflects all previously committed writes.

## Structure
- Shared package sparc_mem_pkg holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - RW encodings RD=1, WR=0;
  - FSM state typedef mem_state_t.
- The byte array is named `ram` so benches can preload it hierarchically with $readmemb before reset.
- One natural sub-module, mem_align_fmt: combinational alignment check, big-endian byte-lane assembly and load extension. The FSM, counter and array stay in the top module.

## Test plan
- Preload ram[0..3]=9C 04 40 12; word read at ADDR=0 -> MFC rises 2 cycles after acceptance, DATA_OUT=32'h9C044012, ALIGN_ERR=0.
- Signed byte read at ADDR=0 -> DATA_OUT=32'hFFFFFF9C. Unsigned halfword read at ADDR=2 -> DATA_OUT=32'h00004012.
- Halfword write DATA_IN=32'h1234ABCD at ADDR=6, then word read at ADDR=4 -> bytes 6..7 are AB CD, bytes 4..5 unchanged.
- Word write at ADDR=2 -> MFC with ALIGN_ERR=1. A following read shows ram[2..5] unchanged.
- Word write at ADDR=32'h0000_0104 with DEPTH=256 -> data lands at ram[4..7].
- Abort and reset:
  - MFA dropped after 1 BUSY cycle of a write -> no MFC, memory unchanged.
  - Reset asserted during BUSY -> MFC=0, DATA_OUT=0, next request is served normally.
